// File: rtl/pdm_decoder.sv
// Pulse-density stream decoder: counts ones over non-overlapping windows of
// 2^DATA_BITS accepted samples and delivers one saturated amplitude word per window.
module pdm_decoder #(
    parameter int unsigned DATA_BITS   = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pdm_in,
    output logic [DATA_BITS-1:0] amplitude,
    output logic                 amplitude_valid,
    input  logic                 amplitude_ready,
    output logic                 overrun
);

    localparam int unsigned CNT_W = DATA_BITS + 1;
    localparam logic [DATA_BITS-1:0] LAST_SAMPLE = '1;

    logic                 w_s;
    logic                 w_window_end;
    logic                 w_handshake;
    logic [CNT_W-1:0]     w_sum;
    logic [DATA_BITS-1:0] w_result;

    logic [DATA_BITS-1:0] r_sample_count;
    logic [CNT_W-1:0]     r_ones_count;
    logic [DATA_BITS-1:0] r_amplitude;
    logic                 r_first_window;
    logic                 r_valid;
    logic                 r_overrun;

    // Input synchroniser; shifts every cycle independent of enable.
    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign w_s = pdm_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= pdm_in;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // The full count of 2^DATA_BITS (all-ones window) clamps to the largest amplitude.
    assign w_window_end = enable && (r_sample_count == LAST_SAMPLE);
    assign w_handshake  = r_valid && amplitude_ready;
    assign w_sum        = r_ones_count + CNT_W'(w_s);
    assign w_result     = w_sum[DATA_BITS] ? LAST_SAMPLE : w_sum[DATA_BITS-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sample_count <= '0;
            r_ones_count   <= '0;
            r_amplitude    <= '0;
            r_first_window <= 1'b1;
            r_valid        <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (enable) begin
                r_sample_count <= r_sample_count + DATA_BITS'(1);
                r_ones_count   <= w_window_end ? '0 : w_sum;
            end
            // First window after reset covers synchroniser fill and is dropped.
            if (w_window_end) begin
                if (r_first_window) begin
                    r_first_window <= 1'b0;
                end else begin
                    r_amplitude <= w_result;
                    r_valid     <= 1'b1;
                    if (r_valid && !amplitude_ready) begin
                        r_overrun <= 1'b1;
                    end
                end
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign amplitude       = r_amplitude;
    assign amplitude_valid = r_valid;
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_pdm_decoder.sv
// Bench for pdm_decoder: encoder-driven stimulus, a window-count model feeding a
// word scoreboard, and per-scenario inline checks.
module tb_pdm_decoder;

    localparam int unsigned DB  = 4;
    localparam int unsigned SS  = 2;
    localparam int          WIN = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          pdm_in;
    logic          amplitude_ready;
    logic [DB-1:0] amplitude;
    logic          amplitude_valid;
    logic          overrun;

    int n_vec = 0;
    int n_err = 0;

    pdm_decoder #(.DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .pdm_in          (pdm_in),
        .amplitude       (amplitude),
        .amplitude_valid (amplitude_valid),
        .amplitude_ready (amplitude_ready),
        .overrun         (overrun)
    );

    always #5 clock = ~clock;

    // Stimulus source: constant level or first-order pulse-density encoder.
    bit src_enc   = 1'b0;
    bit src_const = 1'b0;
    bit enc_pause = 1'b0;
    int enc_amp   = 0;
    int enc_acc   = 0;

    always begin
        @(negedge clock);
        #1;
        if (src_enc) begin
            if (enc_pause) begin
                pdm_in = 1'b0;
            end else begin
                enc_acc += enc_amp;
                if (enc_acc >= WIN) begin
                    pdm_in = 1'b1;
                    enc_acc -= WIN;
                end else begin
                    pdm_in = 1'b0;
                end
            end
        end else begin
            pdm_in = src_const;
        end
    end

    // Reference model and scoreboard, evaluated just after each rising edge.
    logic [SS-1:0] m_dly;
    logic [DB-1:0] prev_amp;
    int m_cnt, m_ones, m_s, m_res, m_pop;
    bit m_first, m_ovr, m_hs;
    int q[$];
    int last_delivered = -1;

    always begin
        @(posedge clock);
        #1;
        if (reset) begin
            m_dly = '0;
            m_cnt = 0;
            m_ones = 0;
            m_first = 1'b1;
            m_ovr = 1'b0;
            q.delete();
            last_delivered = -1;
        end else begin
            m_s  = int'(m_dly[SS-1]);
            m_hs = (q.size() != 0) && amplitude_ready;
            if (m_hs) begin
                m_pop = q.pop_front();
                n_vec++;
                if (prev_amp !== DB'(m_pop)) begin
                    n_err++;
                    $display("FAIL word: got %0d expected %0d", prev_amp, m_pop);
                end
                last_delivered = m_pop;
            end
            if (enable) begin
                if (m_cnt == WIN - 1) begin
                    m_res = m_ones + m_s;
                    if (m_res > WIN - 1) m_res = WIN - 1;
                    m_ones = 0;
                    m_cnt = 0;
                    if (m_first) begin
                        m_first = 1'b0;
                    end else begin
                        if (q.size() != 0) begin
                            void'(q.pop_back());
                            m_ovr = 1'b1;
                        end
                        q.push_back(m_res);
                    end
                end else begin
                    m_ones += m_s;
                    m_cnt++;
                end
            end
            m_dly = {m_dly[SS-2:0], pdm_in};
        end
        n_vec++;
        if (amplitude_valid !== (q.size() != 0)) begin
            n_err++;
            $display("FAIL valid: got %0b expected %0b", amplitude_valid, q.size() != 0);
        end
        n_vec++;
        if (overrun !== m_ovr) begin
            n_err++;
            $display("FAIL overrun_track: got %0b expected %0b", overrun, m_ovr);
        end
        prev_amp = amplitude;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_cnt(input int target);
        int k;
        k = 0;
        while (m_cnt != target && k < 4 * WIN) begin
            tick();
            k++;
        end
        n_vec++;
        if (m_cnt != target) begin
            n_err++;
            $display("FAIL wait_cnt timeout: got %0d expected %0d", m_cnt, target);
        end
    endtask

    task automatic test_reset();
        src_enc = 1'b0;
        src_const = 1'b0;
        repeat (3) begin
            tick();
            n_vec++;
            if (amplitude !== '0) begin
                n_err++; $display("FAIL reset_amp: got %0d expected 0", amplitude);
            end
            n_vec++;
            if (amplitude_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_valid: got %0b expected 0", amplitude_valid);
            end
            n_vec++;
            if (overrun !== 1'b0) begin
                n_err++; $display("FAIL reset_overrun: got %0b expected 0", overrun);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_stream();
        int nv;
        nv = 0;
        repeat (50) begin
            tick();
            if (amplitude_valid === 1'b1) nv++;
        end
        n_vec++;
        if (nv !== 2) begin
            n_err++; $display("FAIL zero_valid_pulses: got %0d expected 2", nv);
        end
        n_vec++;
        if (amplitude !== '0) begin
            n_err++; $display("FAIL zero_amp: got %0d expected 0", amplitude);
        end
    endtask

    task automatic test_saturation();
        src_const = 1'b1;
        repeat (4 * WIN) tick();
        n_vec++;
        if (last_delivered !== 15) begin
            n_err++; $display("FAIL sat_word: got %0d expected 15", last_delivered);
        end
        n_vec++;
        if (amplitude !== 4'd15) begin
            n_err++; $display("FAIL sat_amp: got %0d expected 15", amplitude);
        end
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++; $display("FAIL sat_overrun: got %0b expected 0", overrun);
        end
    endtask

    task automatic test_amplitude_step();
        enc_acc = 0;
        enc_amp = 5;
        src_enc = 1'b1;
        repeat (4 * WIN) tick();
        n_vec++;
        if (last_delivered !== 5) begin
            n_err++; $display("FAIL step_before: got %0d expected 5", last_delivered);
        end
        enc_amp = 11;
        repeat (4 * WIN) tick();
        n_vec++;
        if (last_delivered !== 11) begin
            n_err++; $display("FAIL step_after: got %0d expected 11", last_delivered);
        end
    endtask

    task automatic test_enable_stall();
        enc_amp = 3;
        repeat (4 * WIN) tick();
        wait_cnt(5);
        // Pause the encoder so the bits dropped by the stall are exactly its idle bits.
        enc_pause = 1'b1;
        repeat (2) tick();
        enable = 1'b0;
        repeat (5) tick();
        enc_pause = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        repeat (3 * WIN) tick();
        n_vec++;
        if (last_delivered !== 3) begin
            n_err++; $display("FAIL stall_word: got %0d expected 3", last_delivered);
        end
        amplitude_ready = 1'b0;
        wait_cnt(15);
        tick();
        wait_cnt(15);
        amplitude_ready = 1'b1;
        tick();
        n_vec++;
        if (amplitude_valid !== 1'b1) begin
            n_err++; $display("FAIL coincide_valid: got %0b expected 1", amplitude_valid);
        end
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++; $display("FAIL coincide_overrun: got %0b expected 0", overrun);
        end
        n_vec++;
        if (amplitude !== 4'd3) begin
            n_err++; $display("FAIL coincide_amp: got %0d expected 3", amplitude);
        end
        tick();
        n_vec++;
        if (amplitude_valid !== 1'b0) begin
            n_err++; $display("FAIL coincide_drain: got %0b expected 0", amplitude_valid);
        end
    endtask

    task automatic test_overrun();
        enc_amp = 9;
        repeat (4 * WIN) tick();
        amplitude_ready = 1'b0;
        repeat (40) tick();
        n_vec++;
        if (amplitude_valid !== 1'b1) begin
            n_err++; $display("FAIL ovr_valid: got %0b expected 1", amplitude_valid);
        end
        n_vec++;
        if (amplitude !== 4'd9) begin
            n_err++; $display("FAIL ovr_amp: got %0d expected 9", amplitude);
        end
        n_vec++;
        if (overrun !== 1'b1) begin
            n_err++; $display("FAIL ovr_set: got %0b expected 1", overrun);
        end
        wait_cnt(3);
        amplitude_ready = 1'b1;
        tick();
        n_vec++;
        if (amplitude_valid !== 1'b0) begin
            n_err++; $display("FAIL ovr_drain: got %0b expected 0", amplitude_valid);
        end
        repeat (2 * WIN) tick();
        n_vec++;
        if (overrun !== 1'b1) begin
            n_err++; $display("FAIL ovr_sticky: got %0b expected 1", overrun);
        end
    endtask

    task automatic test_mid_reset();
        int nv;
        enc_amp = 7;
        repeat (4 * WIN) tick();
        wait_cnt(9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (amplitude !== '0) begin
            n_err++; $display("FAIL mid_reset_amp: got %0d expected 0", amplitude);
        end
        n_vec++;
        if (amplitude_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_valid: got %0b expected 0", amplitude_valid);
        end
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_overrun: got %0b expected 0", overrun);
        end
        nv = 0;
        repeat (WIN) begin
            tick();
            if (amplitude_valid === 1'b1) nv++;
        end
        n_vec++;
        if (nv !== 0) begin
            n_err++; $display("FAIL mid_reset_discard: got %0d expected 0", nv);
        end
        repeat (3 * WIN) tick();
        n_vec++;
        if (last_delivered !== 7) begin
            n_err++; $display("FAIL mid_reset_word: got %0d expected 7", last_delivered);
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        amplitude_ready = 1'b1;
        pdm_in = 1'b0;
        test_reset();
        test_zero_stream();
        test_saturation();
        test_amplitude_step();
        test_enable_stall();
        test_overrun();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pdm_decoder.md
Name: pdm_decoder

Overview:
Recovers a DATA_BITS-wide amplitude from a 1-bit pulse-density stream by counting ones over fixed, non-overlapping windows of 2^DATA_BITS samples. It is the receive-side counterpart of the team's pulse-density encoder: an encoder driven with constant amplitude A yields exactly A ones in every window of 2^DATA_BITS consecutive samples. It sits between a PDM pin (or loopback) and downstream logic, and delivers one amplitude word per window over a valid/ready handshake.

Parameters:
DATA_BITS, 10, amplitude width; window length = 2^DATA_BITS accepted samples.
SYNC_STAGES, 2, flops in the pdm_in synchroniser; 0 = bypass (pdm_in used directly).

Ports:
clock  input  1  sole clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  1 = accept one sample this cycle; 0 = freeze window counters.
pdm_in  input  1  pulse-density bitstream, one bit per clock.
amplitude  output  DATA_BITS  registered decoded amplitude of the last completed window.
amplitude_valid  output  1  amplitude holds an undelivered word.
amplitude_ready  input  1  consumer accepts the word when valid&&ready.
overrun  output  1  sticky: a word was overwritten before it was accepted.

Behaviour:
- Reset (sampled at a clock edge): sync flops=0, sample_count=0, ones_count=0, amplitude=0, amplitude_valid=0, overrun=0, first_window flag=1. Reset overrides all other inputs in the same cycle. Reset mid-window discards the partial count.
- Synchroniser: s = pdm_in delayed SYNC_STAGES clocks; it shifts every cycle regardless of enable.
- Accepted sample: a cycle with enable=1 and reset=0. Each accepted sample adds s to ones_count (DATA_BITS+1 bits) and increments sample_count (DATA_BITS bits, wraps).
- Window end: the accepted sample with sample_count == 2^DATA_BITS-1. On that edge:
  - result = ones_count + s, saturated to 2^DATA_BITS-1 (all-ones input gives 2^N, clamped).
  - ones_count <= 0; sample_count wraps to 0.
  - If first_window=1: result discarded, first_window <= 0, valid unchanged. This discard covers synchroniser fill and arbitrary alignment after reset.
  - Else: amplitude <= result; amplitude_valid <= 1 from the next cycle.
- enable=0: sample_count and ones_count hold, so the window stretches by the disabled cycles. The handshake still operates.
- Handshake: when amplitude_valid && amplitude_ready and no window end this cycle, valid <= 0. amplitude is not cleared; it holds the last value.
- Window end coincident with valid&&ready: the new word loads, valid stays 1, no overrun.
- Window end while valid=1 and ready=0: amplitude is overwritten with the new result, valid stays 1, overrun <= 1.
- overrun clears only on reset.
- Latency: from a pdm_in bit to its inclusion in ones_count is SYNC_STAGES+1 edges. From the window-end edge to amplitude_valid high is 1 cycle, since it is registered.
- Throughput: one word per 2^DATA_BITS accepted samples.
- Outputs are fully registered; there is no combinational path from inputs to outputs.
- Exactness: with a steady encoder amplitude A and continuous enable, every reported window equals A.

Test Plan:
1. DATA_BITS=4, SYNC_STAGES=2: assert reset 3 cycles, then hold pdm_in=0 with enable=1 and ready=1 -> all outputs 0 during reset. First window is discarded. amplitude_valid pulses 1 cycle every 16 cycles with amplitude=0.
2. pdm_in=1 constant, ready=1 -> after the discarded first window, amplitude=15 (saturated from 16) every 16 cycles; overrun stays 0.
3. Drive pdm_in from a behavioural pulse-density encoder model at amplitude 5, then step to 11 -> windows wholly after the step report exactly 11. Earlier windows report 5. At most one straddling window gives an intermediate value.
4. Encoder amplitude 9, ready=0 for 40 cycles -> valid stays high, amplitude=9, overrun=1 after the second completed window. Raising ready drops valid next cycle; overrun stays 1 until reset.
5. enable=0 for 7 cycles mid-window, encoder amplitude 3 -> that window completes 7 cycles later and still reports 3. Then assert ready exactly on a window-end cycle -> valid stays 1 and overrun stays 0.
6. Assert reset for 1 cycle at sample 9 of a window -> next cycle amplitude=0, valid=0, overrun=0. Following window is discarded; the window after that reports the correct encoder amplitude.
